// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit MIPS core: data-memory access over req/ack with
// upstream stall, bounded wait and a sticky timeout error flag.
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_MemRead,
  input  logic              in_MemWrite,
  input  logic              in_MemtoReg,
  input  logic              in_RegWrite,
  input  logic [DATA_W-1:0] in_ALUResult,
  input  logic [DATA_W-1:0] in_WriteData,
  input  logic [REG_AW-1:0] in_WriteRegister,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              O_valid,
  output logic              O_MemtoReg,
  output logic [DATA_W-1:0] O_ReadData,
  output logic [DATA_W-1:0] O_ALUResult,
  output logic [REG_AW-1:0] O_WriteRegister,
  output logic              O_RegWrite,
  output logic              err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic                lat_m2r_q, lat_m2r_d, lat_rw_q, lat_rw_d;
  logic [DATA_W-1:0]   lat_alu_q, lat_alu_d;
  logic [REG_AW-1:0]   lat_wreg_q, lat_wreg_d;
  logic                o_valid_q, o_valid_d, o_m2r_q, o_m2r_d, o_rw_q, o_rw_d;
  logic [DATA_W-1:0]   o_rd_q, o_rd_d, o_alu_q, o_alu_d;
  logic [REG_AW-1:0]   o_wreg_q, o_wreg_d;
  logic                err_q, err_d;

  logic mem_op, timeout_hit;

  assign mem_op      = in_valid & (in_MemRead | in_MemWrite);
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign stall       = ((state_q == IDLE) & mem_op) | ((state_q == WAIT) & ~dmem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = WAIT;
      WAIT:    if (dmem_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next-values; O_valid and O_RegWrite default low so a
  // bubble never carries a register write.
  always_comb begin
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_m2r_d  = lat_m2r_q;
    lat_rw_d   = lat_rw_q;
    lat_alu_d  = lat_alu_q;
    lat_wreg_d = lat_wreg_q;
    o_valid_d  = 1'b0;
    o_rw_d     = 1'b0;
    o_m2r_d    = o_m2r_q;
    o_rd_d     = o_rd_q;
    o_alu_d    = o_alu_q;
    o_wreg_d   = o_wreg_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          req_d      = 1'b1;
          we_d       = in_MemWrite;
          addr_d     = in_ALUResult;
          wdata_d    = in_WriteData;
          lat_m2r_d  = in_MemtoReg;
          lat_rw_d   = in_RegWrite;
          lat_alu_d  = in_ALUResult;
          lat_wreg_d = in_WriteRegister;
          cnt_d      = 8'd0;
        end else if (in_valid) begin
          o_valid_d = 1'b1;
          o_rw_d    = in_RegWrite;
          o_m2r_d   = in_MemtoReg;
          o_rd_d    = '0;
          o_alu_d   = in_ALUResult;
          o_wreg_d  = in_WriteRegister;
        end
      end
      WAIT: begin
        if (dmem_ack || timeout_hit) begin
          req_d     = 1'b0;
          cnt_d     = 8'd0;
          o_valid_d = 1'b1;
          o_m2r_d   = lat_m2r_q;
          o_alu_d   = lat_alu_q;
          o_wreg_d  = lat_wreg_q;
          if (dmem_ack) begin
            o_rw_d = lat_rw_q;
            o_rd_d = we_q ? '0 : dmem_rdata;
          end else begin
            o_rd_d = '0;
            err_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_m2r_q  <= 1'b0;
      lat_rw_q   <= 1'b0;
      lat_alu_q  <= '0;
      lat_wreg_q <= '0;
      o_valid_q  <= 1'b0;
      o_m2r_q    <= 1'b0;
      o_rd_q     <= '0;
      o_alu_q    <= '0;
      o_wreg_q   <= '0;
      o_rw_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_m2r_q  <= lat_m2r_d;
      lat_rw_q   <= lat_rw_d;
      lat_alu_q  <= lat_alu_d;
      lat_wreg_q <= lat_wreg_d;
      o_valid_q  <= o_valid_d;
      o_m2r_q    <= o_m2r_d;
      o_rd_q     <= o_rd_d;
      o_alu_q    <= o_alu_d;
      o_wreg_q   <= o_wreg_d;
      o_rw_q     <= o_rw_d;
      err_q      <= err_d;
    end
  end

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign O_valid         = o_valid_q;
  assign O_MemtoReg      = o_m2r_q;
  assign O_ReadData      = o_rd_q;
  assign O_ALUResult     = o_alu_q;
  assign O_WriteRegister = o_wreg_q;
  assign O_RegWrite      = o_rw_q;
  assign err             = err_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage of the 16-bit MIPS core. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs load/store access to the data memory over a req/ack handshake and stalls upstream while an access is outstanding.
- Drives the MEM/WB register inputs (MemtoReg, ReadData, ALUResult, WriteRegister, RegWrite) plus a valid flag.
- Has a bounded-wait timeout with a sticky error flag.

Parameters:
- DATA_W, 16, datapath / memory data and address width
- REG_AW, 3, register-file address width (8 registers)
- TIMEOUT, 15, maximum WAIT cycles without dmem_ack before abort (1..255)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a live instruction
- in_MemRead  in  1  load
- in_MemWrite  in  1  store
- in_MemtoReg  in  1  writeback selects memory data
- in_RegWrite  in  1  instruction writes register file
- in_ALUResult  in  DATA_W  ALU result; memory address for loads/stores
- in_WriteData  in  DATA_W  store data
- in_WriteRegister  in  REG_AW  destination register
- stall  out  1  upstream must hold EX/MEM contents (combinational)
- dmem_req  out  1  memory request (registered)
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DATA_W  memory address
- dmem_wdata  out  DATA_W  memory write data
- dmem_rdata  in  DATA_W  memory read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- O_valid  out  1  outputs carry a completed instruction this cycle
- O_MemtoReg  out  1  to MEM/WB
- O_ReadData  out  DATA_W  to MEM/WB
- O_ALUResult  out  DATA_W  to MEM/WB
- O_WriteRegister  out  REG_AW  to MEM/WB
- O_RegWrite  out  1  to MEM/WB; never 1 unless O_valid=1
- err  out  1  sticky timeout error

Behaviour:
- Reset: state=IDLE. All outputs are 0, including dmem_req, dmem_we, dmem_addr, dmem_wdata, O_*, err; wait counter=0. Takes effect immediately and asynchronously, including mid-access, so dmem_req drops at once.
- Output registers are posedge-updated, so they are stable before MEM/WB samples on negedge.
- States: IDLE, WAIT.
- stall = (IDLE & in_valid & (in_MemRead | in_MemWrite)) | (WAIT & ~dmem_ack).
- IDLE, in_valid=0:
  - next edge: O_valid=0, O_RegWrite=0; other O_* hold.
- IDLE, in_valid=1, no memory op:
  - next edge: O_* load from in_*; O_ReadData=0; O_valid=1. Latency is 1 cycle.
- IDLE, in_valid=1, MemRead or MemWrite:
  - next edge: go to WAIT; dmem_req=1; dmem_we=in_MemWrite; dmem_addr=in_ALUResult; dmem_wdata=in_WriteData.
  - MemtoReg, RegWrite, ALUResult and WriteRegister are latched internally; counter=0; O_valid=0, O_RegWrite=0.
  - If MemRead and MemWrite are both 1, the access is treated as a write.
- WAIT, dmem_ack=1:
  - stall drops in the same cycle.
  - next edge: dmem_req=0; go to IDLE; O_* load from the latched fields; O_valid=1.
  - O_ReadData = dmem_rdata for a read, 0 for a write.
  - Upstream advances on the same edge. Minimum memory-op latency is 2 cycles (presented→req, ack→output).
- WAIT, dmem_ack=0:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable; counter+1; O_valid=0.
  - If the counter reaches TIMEOUT-1 without ack, next edge: dmem_req=0, err=1, go to IDLE, O_valid=1, O_RegWrite=0. The instruction retires as a bubble and stall releases.
- err stays 1 until reset.
- dmem_ack in IDLE is ignored.
- The counter wraps only through the timeout path and never overflows.
- dmem_addr and dmem_wdata hold their last values after an access; only dmem_req qualifies them.

Test Plan:
- Non-memory op: in_valid=1, RegWrite=1, ALUResult=16'h1234, WriteRegister=3'd5, no mem op → next edge O_valid=1, O_ALUResult=1234, O_WriteRegister=5, O_RegWrite=1, O_ReadData=0; stall never high.
- Load with ack after 3 WAIT cycles: ALUResult=16'h0040, MemRead=1, MemtoReg=1, WriteRegister=2.
  - stall=1 for 4 cycles; dmem_req=1, dmem_we=0, dmem_addr=0040.
  - ack with rdata=16'hBEEF → next edge O_ReadData=BEEF, O_MemtoReg=1, O_RegWrite=1, O_valid=1; stall=0 in the ack cycle.
- Store with immediate ack: MemWrite=1, ALUResult=16'h0010, WriteData=16'hA5A5 → dmem_we=1, dmem_addr=0010, dmem_wdata=A5A5; ack next cycle → O_valid=1, O_RegWrite=0, O_ReadData=0; total 2 cycles.
- Back-to-back: load followed by non-memory op → second instruction is accepted on the ack edge; its outputs appear 1 cycle after the load's, with no lost or duplicated O_valid.
- Timeout: load, dmem_ack never asserted → after 15 WAIT cycles dmem_req=0, err=1 (sticky), O_valid=1 with O_RegWrite=0, stall=0; a later op still completes normally with err still 1.
- Reset mid-access: rst_n=0 during WAIT → dmem_req, stall-causing state, O_* and err all 0 immediately; after release, an ack arriving in IDLE is ignored.
